// File: rtl/n25q_target.sv
// SPI mode-0 flash responder emulating the N25Q command subset on a byte-wide memory port.
// Latency: ~3 ifclk from an sclk edge to its effect; mem_we one cycle after the 8th data rise. Backpressure: none, memory must accept every strobe.
module n25q_target #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'h20BA18
) (
    input  logic              ifclk,
    input  logic              resetb,
    input  logic              sclk,
    input  logic              csb,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              wel
);
    typedef enum logic [2:0] {S_CMD, S_ADDR, S_DUMMY, S_DOUT, S_DIN, S_IGNORE} state_t;
    localparam logic [1:0] SRC_MEM = 2'd0, SRC_ID = 2'd1, SRC_SR = 2'd2;
    localparam logic [1:0] WOP_NONE = 2'd0, WOP_SET = 2'd1, WOP_CLR = 2'd2;

    state_t            state_q, state_d;
    logic [2:0]        sclk_sync_q, sclk_sync_d, csb_sync_q, csb_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       rx_q, rx_d;
    logic [7:0]        op_q, op_d, tx_q, tx_d, buf_q, buf_d, wdata_q, wdata_d;
    logic [1:0]        src_q, src_d, id_idx_q, id_idx_d, wel_op_q, wel_op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              miso_q, miso_d, re_q, re_d, we_q, we_d, rd_cap_q, rd_cap_d, wel_q, wel_d;

    logic        rise, fall, csb_s, csb_rise, mosi_s, byte_end;
    logic [23:0] rx_full;
    logic [7:0]  byte_out;

    assign rise     = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign fall     = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign csb_s    = csb_sync_q[1];
    assign csb_rise = csb_sync_q[1] & ~csb_sync_q[2];
    assign mosi_s   = mosi_sync_q[1];
    assign rx_full  = {rx_q, mosi_s};
    assign byte_end = (bit_cnt_q == ((state_q == S_ADDR) ? 5'd23 : 5'd7));

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) state_q <= S_CMD;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (csb_s) begin
            state_d = S_CMD;
        end else if (rise && byte_end) begin
            case (state_q)
                S_CMD: begin
                    case (rx_full[7:0])
                        8'h9F, 8'h05:        state_d = S_DOUT;
                        8'h03, 8'h0B, 8'h02: state_d = S_ADDR;
                        default:             state_d = S_IGNORE;
                    endcase
                end
                S_ADDR: begin
                    if (op_q == 8'h0B)      state_d = S_DUMMY;
                    else if (op_q == 8'h02) state_d = wel_q ? S_DIN : S_IGNORE;
                    else                    state_d = S_DOUT;
                end
                S_DUMMY: state_d = S_DOUT;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        miso    = (state_q == S_DOUT) && miso_q;
        miso_oe = ~csb_s;
    end

    always_comb begin
        case (id_idx_q)
            2'd0:    byte_out = JEDEC_ID[23:16];
            2'd1:    byte_out = JEDEC_ID[15:8];
            2'd2:    byte_out = JEDEC_ID[7:0];
            default: byte_out = 8'h00;
        endcase
        if (src_q == SRC_SR)       byte_out = {6'b0, wel_q, 1'b0};
        else if (src_q == SRC_MEM) byte_out = buf_q;
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        csb_sync_d  = {csb_sync_q[1:0], csb};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        op_d        = op_q;
        tx_d        = tx_q;
        src_d       = src_q;
        id_idx_d    = id_idx_q;
        wel_op_d    = wel_op_q;
        wel_d       = wel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        re_d        = 1'b0;
        we_d        = 1'b0;
        rd_cap_d    = re_q;
        buf_d       = rd_cap_q ? mem_rdata : buf_q;
        miso_d      = (state_q == S_DOUT) ? miso_q : 1'b0;

        // Page-wrapped advance happens while the write strobe is out, so mem_addr is stable under it.
        if (we_q) addr_d[7:0] = addr_q[7:0] + 8'd1;

        if (csb_rise) begin
            if (wel_op_q == WOP_SET)      wel_d = 1'b1;
            else if (wel_op_q == WOP_CLR) wel_d = 1'b0;
            wel_op_d = WOP_NONE;
        end

        if (csb_s) begin
            bit_cnt_d = 5'd0;
        end else begin
            if (rise) begin
                rx_d      = rx_full[22:0];
                bit_cnt_d = byte_end ? 5'd0 : bit_cnt_q + 5'd1;
                if (byte_end) begin
                    case (state_q)
                        S_CMD: begin
                            op_d     = rx_full[7:0];
                            id_idx_d = 2'd0;
                            src_d    = (rx_full[7:0] == 8'h9F) ? SRC_ID :
                                       (rx_full[7:0] == 8'h05) ? SRC_SR : SRC_MEM;
                            if (rx_full[7:0] == 8'h06)                              wel_op_d = WOP_SET;
                            else if (rx_full[7:0] == 8'h04 || rx_full[7:0] == 8'h02) wel_op_d = WOP_CLR;
                        end
                        S_ADDR: begin
                            addr_d = rx_full[ADDR_W-1:0];
                            re_d   = (op_q == 8'h03);
                        end
                        S_DUMMY: re_d = 1'b1;
                        S_DOUT: begin
                            if (src_q == SRC_MEM) begin
                                addr_d = addr_q + ADDR_W'(1);
                                re_d   = 1'b1;
                            end
                        end
                        S_DIN: begin
                            we_d    = 1'b1;
                            wdata_d = rx_full[7:0];
                        end
                        default: ;
                    endcase
                end
            end
            if (fall && state_q == S_DOUT) begin
                if (bit_cnt_q == 5'd0) begin
                    miso_d = byte_out[7];
                    tx_d   = {byte_out[6:0], 1'b0};
                    if (src_q == SRC_ID && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                end else begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            sclk_sync_q <= 3'b000;
            csb_sync_q  <= 3'b111;
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= 5'd0;
            rx_q        <= '0;
            op_q        <= 8'h00;
            tx_q        <= 8'h00;
            buf_q       <= 8'h00;
            src_q       <= SRC_MEM;
            id_idx_q    <= 2'd0;
            wel_op_q    <= WOP_NONE;
            wel_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            rd_cap_q    <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            csb_sync_q  <= csb_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            op_q        <= op_d;
            tx_q        <= tx_d;
            buf_q       <= buf_d;
            src_q       <= src_d;
            id_idx_q    <= id_idx_d;
            wel_op_q    <= wel_op_d;
            wel_q       <= wel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            re_q        <= re_d;
            we_q        <= we_d;
            rd_cap_q    <= rd_cap_d;
            miso_q      <= miso_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign wel       = wel_q;
endmodule
